// File: rtl/naive_bus_arbiter_pkg.sv
// Shared types and constants for the naive_bus round-robin arbiter.
// Optional build macro used by the top: NAIVE_ARB_PERF_CNT_EN.
package naive_arb_pkg;

  localparam int NAIVE_ARB_MAX_MASTER = 8;

  typedef logic [2:0]  arb_idx_t;
  typedef logic [31:0] bus_word_t;

  typedef enum logic {
    FREE = 1'b0,
    HOLD = 1'b1
  } lock_state_e;

  // Next master index after idx, wrapping back to 0 past the last master.
  function automatic arb_idx_t idx_wrap_inc(arb_idx_t idx, int n);
    if (int'(idx) >= n - 1) return '0;
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/naive_bus_arbiter_if.sv
// naive_bus interfaces: a per-master arrayed bundle and a single slave-side bus.
// The "master" modport is the view of whoever issues requests.
interface naive_bus_m_if
  import naive_arb_pkg::*;
#(
  parameter int N_MASTER = 2
);

  logic [N_MASTER-1:0]            rd_req;
  logic [N_MASTER-1:0][3:0]       rd_be;
  logic [N_MASTER-1:0][31:0]      rd_addr;
  logic [N_MASTER-1:0]            rd_gnt;
  logic [N_MASTER-1:0][31:0]      rd_data;
  logic [N_MASTER-1:0]            wr_req;
  logic [N_MASTER-1:0][3:0]       wr_be;
  logic [N_MASTER-1:0][31:0]      wr_addr;
  logic [N_MASTER-1:0][31:0]      wr_data;
  logic [N_MASTER-1:0]            wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

interface naive_bus_s_if
  import naive_arb_pkg::*;
;

  logic      rd_req;
  logic [3:0] rd_be;
  bus_word_t rd_addr;
  logic      rd_gnt;
  bus_word_t rd_data;
  logic      wr_req;
  logic [3:0] wr_be;
  bus_word_t wr_addr;
  bus_word_t wr_data;
  logic      wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    input  rd_gnt, rd_data, wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
    output rd_gnt, rd_data, wr_gnt
  );

endinterface

// File: rtl/naive_bus_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after
// start (wrapping) wins.
module rr_pick
  import naive_arb_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic [N_MASTER-1:0] req,
  input  arb_idx_t            start,
  output logic                vld,
  output arb_idx_t            idx
);

  logic [NAIVE_ARB_MAX_MASTER-1:0] req_pad;
  logic [3:0]                      pos;

  assign req_pad = NAIVE_ARB_MAX_MASTER'(req);

  // Scan from the lowest priority down so the last hit is the winner.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = N_MASTER - 1; k >= 0; k--) begin
      pos = {1'b0, start} + 4'(k);
      if (pos >= 4'(N_MASTER)) pos = pos - 4'(N_MASTER);
      if (req_pad[pos[2:0]]) begin
        vld = 1'b1;
        idx = pos[2:0];
      end
    end
  end

endmodule

// File: rtl/naive_bus_arbiter.sv
// Round-robin arbiter sharing one naive_bus slave among N_MASTER requesters.
// Define NAIVE_ARB_PERF_CNT_EN to build the per-master denied-cycle counters.
module naive_bus_arbiter
  import naive_arb_pkg::*;
#(
  parameter int N_MASTER = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  naive_bus_m_if.slave               m_bus,
  naive_bus_s_if.master              s_bus,
  output logic [N_MASTER-1:0][31:0]  o_conflict_cnt
);

  lock_state_e state_q, state_d;
  arb_idx_t    lock_idx_q, lock_idx_d;
  arb_idx_t    rr_ptr_q, rr_ptr_d;
  arb_idx_t    rd_owner_q, rd_owner_d;
  logic        rd_owner_vld_q, rd_owner_vld_d;

  logic [N_MASTER-1:0] req_vec;
  logic                pick_vld;
  arb_idx_t            pick_idx;
  arb_idx_t            sel;
  logic                sel_act;
  logic                accepted;

  logic       sel_rd_req, sel_wr_req;
  logic [3:0] sel_rd_be, sel_wr_be;
  bus_word_t  sel_rd_addr, sel_wr_addr, sel_wr_data;
  logic       fwd_rd_req, fwd_wr_req;

  assign req_vec = m_bus.rd_req | m_bus.wr_req;

  rr_pick #(
    .N_MASTER (N_MASTER)
  ) u_rr_pick (
    .req   (req_vec),
    .start (rr_ptr_q),
    .vld   (pick_vld),
    .idx   (pick_idx)
  );

  assign sel = (state_q == HOLD) ? lock_idx_q : pick_idx;

  always_comb begin
    sel_rd_req  = 1'b0;
    sel_wr_req  = 1'b0;
    sel_rd_be   = '0;
    sel_wr_be   = '0;
    sel_rd_addr = '0;
    sel_wr_addr = '0;
    sel_wr_data = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (arb_idx_t'(i) == sel) begin
        sel_rd_req  = m_bus.rd_req[i];
        sel_wr_req  = m_bus.wr_req[i];
        sel_rd_be   = m_bus.rd_be[i];
        sel_wr_be   = m_bus.wr_be[i];
        sel_rd_addr = m_bus.rd_addr[i];
        sel_wr_addr = m_bus.wr_addr[i];
        sel_wr_data = m_bus.wr_data[i];
      end
    end
  end

  // A held master that has dropped everything forwards nothing this cycle.
  assign sel_act  = (state_q == HOLD) ? (sel_rd_req | sel_wr_req) : pick_vld;
  assign accepted = sel_act & (~sel_rd_req | s_bus.rd_gnt) & (~sel_wr_req | s_bus.wr_gnt);

  assign fwd_rd_req    = sel_act & sel_rd_req;
  assign fwd_wr_req    = sel_act & sel_wr_req;
  assign s_bus.rd_req  = fwd_rd_req;
  assign s_bus.rd_be   = sel_act ? sel_rd_be   : '0;
  assign s_bus.rd_addr = sel_act ? sel_rd_addr : '0;
  assign s_bus.wr_req  = fwd_wr_req;
  assign s_bus.wr_be   = sel_act ? sel_wr_be   : '0;
  assign s_bus.wr_addr = sel_act ? sel_wr_addr : '0;
  assign s_bus.wr_data = sel_act ? sel_wr_data : '0;

  always_comb begin
    m_bus.rd_gnt  = '0;
    m_bus.wr_gnt  = '0;
    m_bus.rd_data = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (sel_act && arb_idx_t'(i) == sel) begin
        m_bus.rd_gnt[i] = s_bus.rd_gnt & m_bus.rd_req[i];
        m_bus.wr_gnt[i] = s_bus.wr_gnt & m_bus.wr_req[i];
      end
      if (rd_owner_vld_q && rd_owner_q == arb_idx_t'(i)) begin
        m_bus.rd_data[i] = s_bus.rd_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      FREE: begin
        if (sel_act && !accepted) begin
          state_d    = HOLD;
          lock_idx_d = sel;
        end
      end
      HOLD: begin
        if (accepted || !sel_act) state_d = FREE;
      end
    endcase
    if (accepted) rr_ptr_d = idx_wrap_inc(sel, N_MASTER);
    rd_owner_vld_d = s_bus.rd_gnt & fwd_rd_req;
    rd_owner_d     = rd_owner_vld_d ? sel : rd_owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FREE;
      lock_idx_q     <= '0;
      rr_ptr_q       <= '0;
      rd_owner_q     <= '0;
      rd_owner_vld_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      lock_idx_q     <= lock_idx_d;
      rr_ptr_q       <= rr_ptr_d;
      rd_owner_q     <= rd_owner_d;
      rd_owner_vld_q <= rd_owner_vld_d;
    end
  end

`ifdef NAIVE_ARB_PERF_CNT_EN
  logic [N_MASTER-1:0][31:0] cnt_q, cnt_d;

  // Denied covers both losing arbitration and a stalled slave.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_MASTER; i++) begin
      if (req_vec[i] && !(accepted && arb_idx_t'(i) == sel) && cnt_q[i] != 32'hFFFF_FFFF) begin
        cnt_d[i] = cnt_q[i] + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_conflict_cnt = cnt_q;
`else
  assign o_conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_naive_bus_arbiter.sv
// Directed, table-driven bench for naive_bus_arbiter with two masters.
module tb_naive_bus_arbiter;
  import naive_arb_pkg::*;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0][31:0] cnt;

  always #5 clk = ~clk;

  naive_bus_m_if #(.N_MASTER(N)) m_bus ();
  naive_bus_s_if                 s_bus ();

  naive_bus_arbiter #(
    .N_MASTER (N)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .m_bus          (m_bus),
    .s_bus          (s_bus),
    .o_conflict_cnt (cnt)
  );

  typedef struct {
    logic [1:0]  rd_req;
    logic [1:0]  wr_req;
    logic        s_rd_gnt;
    logic        s_wr_gnt;
    logic [31:0] s_rd_data;
    logic [1:0]  e_rd_gnt;
    logic [1:0]  e_wr_gnt;
    logic [31:0] e_rd_addr;
    logic        e_s_wr_req;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
  } vec_t;

  vec_t vec [14];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cnt1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] rr, input logic [1:0] wr, input logic sg,
                       input logic swg, input logic [31:0] sd);
    m_bus.rd_req  = rr;
    m_bus.wr_req  = wr;
    s_bus.rd_gnt  = sg;
    s_bus.wr_gnt  = swg;
    s_bus.rd_data = sd;
  endtask

  task automatic do_reset();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    m_bus.rd_be   = {4'hF, 4'hF};
    m_bus.wr_be   = {4'h3, 4'hC};
    m_bus.rd_addr = {32'h0000_0200, 32'h0000_0100};
    m_bus.wr_addr = {32'h0000_0400, 32'h0000_0300};
    m_bus.wr_data = {32'h1111_2222, 32'h3333_4444};
    exp_cnt1 = 32'd0;
`ifdef NAIVE_ARB_PERF_CNT_EN
    exp_cnt1 = 32'd5;
`endif

    //               rd    wr    sg swg sdata          erg   ewg   eaddr         eswr ed0           ed1
    vec[0]  = '{2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 32'h0,   0, 32'h0,        32'h0};
    vec[1]  = '{2'b01, 2'b00, 1, 0, 32'h0,        2'b01, 2'b00, 32'h100, 0, 32'h0,        32'h0};
    vec[2]  = '{2'b00, 2'b00, 0, 0, 32'hDEADBEEF, 2'b00, 2'b00, 32'h0,   0, 32'hDEADBEEF, 32'h0};
    vec[3]  = '{2'b11, 2'b00, 1, 0, 32'h0,        2'b10, 2'b00, 32'h200, 0, 32'h0,        32'h0};
    vec[4]  = '{2'b11, 2'b00, 1, 0, 32'hA200,     2'b01, 2'b00, 32'h100, 0, 32'h0,        32'hA200};
    vec[5]  = '{2'b11, 2'b00, 1, 0, 32'hA100,     2'b10, 2'b00, 32'h200, 0, 32'hA100,     32'h0};
    vec[6]  = '{2'b00, 2'b00, 1, 0, 32'hB200,     2'b00, 2'b00, 32'h0,   0, 32'h0,        32'hB200};
    vec[7]  = '{2'b01, 2'b10, 1, 1, 32'h0,        2'b01, 2'b00, 32'h100, 0, 32'h0,        32'h0};
    vec[8]  = '{2'b00, 2'b10, 1, 1, 32'hC100,     2'b00, 2'b10, 32'h200, 1, 32'hC100,     32'h0};
    vec[9]  = '{2'b00, 2'b00, 0, 0, 32'h0,        2'b00, 2'b00, 32'h0,   0, 32'h0,        32'h0};
    vec[10] = '{2'b01, 2'b01, 1, 0, 32'h0,        2'b01, 2'b00, 32'h100, 1, 32'h0,        32'h0};
    vec[11] = '{2'b10, 2'b01, 1, 1, 32'hD100,     2'b00, 2'b01, 32'h100, 1, 32'hD100,     32'h0};
    vec[12] = '{2'b10, 2'b00, 1, 0, 32'h0,        2'b10, 2'b00, 32'h200, 0, 32'h0,        32'h0};
    vec[13] = '{2'b00, 2'b00, 0, 0, 32'hE200,     2'b00, 2'b00, 32'h0,   0, 32'h0,        32'hE200};

    // Reset state
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    #2;
    chk("rst_rd_gnt", 32'(m_bus.rd_gnt), 32'h0);
    chk("rst_s_rd_req", 32'(s_bus.rd_req), 32'h0);
    chk("rst_rd_data0", m_bus.rd_data[0], 32'h0);
    chk("rst_rd_data1", m_bus.rd_data[1], 32'h0);
    chk("rst_cnt0", cnt[0], 32'h0);
    chk("rst_cnt1", cnt[1], 32'h0);
    rst = 1'b0;
    tick();

    // Table: single read, alternating reads, same-cycle rd/wr, partial grant
    for (int v = 0; v < 14; v++) begin
      drive(vec[v].rd_req, vec[v].wr_req, vec[v].s_rd_gnt, vec[v].s_wr_gnt, vec[v].s_rd_data);
      #2;
      chk($sformatf("v%0d_rd_gnt", v), 32'(m_bus.rd_gnt), 32'(vec[v].e_rd_gnt));
      chk($sformatf("v%0d_wr_gnt", v), 32'(m_bus.wr_gnt), 32'(vec[v].e_wr_gnt));
      chk($sformatf("v%0d_s_rd_addr", v), s_bus.rd_addr, vec[v].e_rd_addr);
      chk($sformatf("v%0d_s_wr_req", v), 32'(s_bus.wr_req), 32'(vec[v].e_s_wr_req));
      chk($sformatf("v%0d_rd_data0", v), m_bus.rd_data[0], vec[v].e_d0);
      chk($sformatf("v%0d_rd_data1", v), m_bus.rd_data[1], vec[v].e_d1);
      if (v == 8) chk("v8_s_wr_addr", s_bus.wr_addr, 32'h400);
      tick();
    end

    // Stalled master1 keeps the bus while master0 arrives mid-stall
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive((c >= 1) ? 2'b11 : 2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
      #2;
      chk($sformatf("stall%0d_addr", c), s_bus.rd_addr, 32'h200);
      chk($sformatf("stall%0d_gnt", c), 32'(m_bus.rd_gnt), 32'h0);
      tick();
    end
    drive(2'b11, 2'b00, 1'b1, 1'b0, 32'h0);
    #2;
    chk("stall_release_gnt", 32'(m_bus.rd_gnt), 32'h2);
    tick();
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    #2;
    chk("stall_next_gnt", 32'(m_bus.rd_gnt), 32'h1);
    chk("stall_next_addr", s_bus.rd_addr, 32'h100);
    tick();

    // Withdrawal from HOLD: one idle cycle, then a fresh selection
    do_reset();
    drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    #2;
    chk("wd_gnt", 32'(m_bus.rd_gnt), 32'h0);
    chk("wd_s_rd_req", 32'(s_bus.rd_req), 32'h0);
    tick();
    #2;
    chk("wd_new_gnt", 32'(m_bus.rd_gnt), 32'h1);
    tick();

    // Reset right after a granted read, with master1 about to hold
    do_reset();
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0);
    tick();
    drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(2'b11, 2'b00, 1'b1, 1'b0, 32'h66);
    #2;
    chk("mrst_rd_data0", m_bus.rd_data[0], 32'h0);
    chk("mrst_rd_data1", m_bus.rd_data[1], 32'h0);
    chk("mrst_gnt", 32'(m_bus.rd_gnt), 32'h1);
    tick();
    drive(2'b10, 2'b00, 1'b1, 1'b0, 32'h0);
    #2;
    chk("mrst_m1_gnt", 32'(m_bus.rd_gnt), 32'h2);
    tick();

    // Conflict counters: master1 denied for five cycles
    do_reset();
    drive(2'b10, 2'b00, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 5; c++) tick();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    #2;
    chk("cnt1", cnt[1], exp_cnt1);
    chk("cnt0", cnt[0], 32'h0);
    tick();
    #2;
    chk("cnt1_idle", cnt[1], exp_cnt1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
